// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM state values and
// requester ownership constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RDATA = 2'b10
  } state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester port.
// master = requester view, slave = arbiter view.
interface mem_arbiter_if #(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32
);
  logic              req;
  logic              we;
  logic [A_SIZE-1:0] addr;
  logic [D_SIZE-1:0] wdata;
  logic              gnt;
  logic              ack;
  logic [D_SIZE-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; the requester that did not win last time
// takes a tie. Purely combinational, the history bit lives in the caller.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       any
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == OWN_M1) ? 2'b01 : 2'b10;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between two requesters, one
// operation at a time, with round-robin arbitration on ties.
//
// state | meaning
// IDLE  | waiting for a request; grant is given combinationally here
// ISSUE | drive memory pins from op registers; writes complete here
// RDATA | memory read data valid; ack + rdata to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic [A_SIZE-1:0] mem_addr,
  output logic [D_SIZE-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [D_SIZE-1:0] mem_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              op_owner;
  logic              op_we;
  logic [A_SIZE-1:0] op_addr;
  logic [D_SIZE-1:0] op_wdata;
  logic [1:0]        pick;
  logic              pick_any;
  logic              take;

  rr_arb2 u_rr_arb2 (
    .req   ({m1.req, m0.req}),
    .last  (last),
    .grant (pick),
    .any   (pick_any)
  );

  assign take = rst && (state == IDLE) && pick_any;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= OWN_M1;
      op_owner <= OWN_M0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        last     <= pick[1];
        op_owner <= pick[1];
        op_we    <= pick[1] ? m1.we    : m0.we;
        op_addr  <= pick[1] ? m1.addr  : m0.addr;
        op_wdata <= pick[1] ? m1.wdata : m0.wdata;
      end
    end
  end

  // Every output is gated by rst so nothing leaks while reset is held.
  always_comb begin
    state_nxt = state;
    m0.gnt    = 1'b0;
    m1.gnt    = 1'b0;
    m0.ack    = 1'b0;
    m1.ack    = 1'b0;
    m0.rdata  = '0;
    m1.rdata  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state_nxt = ISSUE;
            m0.gnt    = pick[0];
            m1.gnt    = pick[1];
          end
        end
        ISSUE: begin
          mem_addr  = op_addr;
          mem_wdata = op_wdata;
          if (op_we) begin
            mem_write = 1'b1;
            state_nxt = IDLE;
            if (op_owner == OWN_M0) m0.ack = 1'b1;
            else                    m1.ack = 1'b1;
          end else begin
            mem_read  = 1'b1;
            state_nxt = RDATA;
          end
        end
        RDATA: begin
          state_nxt = IDLE;
          if (op_owner == OWN_M0) begin
            m0.ack   = 1'b1;
            m0.rdata = mem_rdata;
          end else begin
            m1.ack   = 1'b1;
            m1.rdata = mem_rdata;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, transaction-level reference
// model checked every cycle, directed scenarios plus constrained random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  mem_arbiter_if #(.A_SIZE(10), .D_SIZE(32)) m0_if ();
  mem_arbiter_if #(.A_SIZE(10), .D_SIZE(32)) m1_if ();

  mem_arbiter #(.A_SIZE(10), .D_SIZE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Single-port synchronous memory with a preload port for bench setup.
  logic [31:0] mem_arr [0:1023];
  always @(posedge clk) begin
    if (pl_en)          mem_arr[pl_addr]  <= pl_data;
    else if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    if (mem_read)       mem_rdata <= mem_arr[mem_addr];
  end

  // Reference model: each grant schedules the pin activity it implies for
  // the following one or two cycles; nothing else may appear.
  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        ack0;
    logic        ack1;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } ev_t;

  ev_t         q [0:2];
  logic [31:0] gold [0:1023];
  int          mcyc = 0;
  int          free_at = 0;
  bit          mlast = 1'b1;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, mcyc, act, exp);
    end
  endtask

  task automatic model_step();
    ev_t e;
    bit  gr;
    bit  w;
    bit  we;
    e  = q[0];
    gr = 1'b0;
    w  = 1'b0;
    if (!rst) begin
      chk("rst_m0_gnt", 32'(m0_if.gnt), 0);
      chk("rst_m1_gnt", 32'(m1_if.gnt), 0);
      chk("rst_m0_ack", 32'(m0_if.ack), 0);
      chk("rst_m1_ack", 32'(m1_if.ack), 0);
      chk("rst_m0_rdata", m0_if.rdata, 0);
      chk("rst_m1_rdata", m1_if.rdata, 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      q[0] = '0; q[1] = '0; q[2] = '0;
      free_at = mcyc + 1;
      mlast   = 1'b1;
    end else begin
      if (mcyc >= free_at && (m0_if.req || m1_if.req)) begin
        gr = 1'b1;
        if (m0_if.req && m1_if.req) w = ~mlast;
        else                        w = m1_if.req;
      end
      chk("m0_gnt", 32'(m0_if.gnt), 32'(gr && !w));
      chk("m1_gnt", 32'(m1_if.gnt), 32'(gr && w));
      chk("mem_read", 32'(mem_read), 32'(e.mr));
      chk("mem_write", 32'(mem_write), 32'(e.mw));
      chk("m0_ack", 32'(m0_if.ack), 32'(e.ack0));
      chk("m1_ack", 32'(m1_if.ack), 32'(e.ack1));
      chk("m0_rdata", m0_if.rdata, e.ack0 ? e.rd : 32'h0);
      chk("m1_rdata", m1_if.rdata, e.ack1 ? e.rd : 32'h0);
      if (e.mr || e.mw) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      if (e.mw)         chk("mem_wdata", mem_wdata, e.wd);
      if (e.mw) gold[e.addr] = e.wd;
      if (e.mr) q[1].rd = gold[e.addr];
      if (gr) begin
        we = w ? m1_if.we : m0_if.we;
        q[1] = '0;
        q[1].mr   = !we;
        q[1].mw   = we;
        q[1].ack0 = we && !w;
        q[1].ack1 = we && w;
        q[1].addr = w ? m1_if.addr : m0_if.addr;
        q[1].wd   = w ? m1_if.wdata : m0_if.wdata;
        if (!we) begin
          q[2] = '0;
          q[2].ack0 = !w;
          q[2].ack1 = w;
        end
        free_at = mcyc + (we ? 2 : 3);
        mlast   = w;
      end
    end
    if (pl_en) gold[pl_addr] = pl_data;
    q[0] = q[1]; q[1] = q[2]; q[2] = '0;
    mcyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b0;
    sample();
    advance();
    rst = 1'b1;
  endtask

  task automatic set_m0(input logic r, input logic we, input logic [9:0] a, input logic [31:0] d);
    m0_if.req = r; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic we, input logic [9:0] a, input logic [31:0] d);
    m1_if.req = r; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
  endtask

  function automatic logic [9:0] rnd_addr();
    logic [9:0] a;
    a = 10'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a = a | 10'h3F0;
    return a;
  endfunction

  initial begin
    bit g0;
    bit g1;
    rst = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    q[0] = '0; q[1] = '0; q[2] = '0;

    // Preload every word while held in reset.
    for (int i = 0; i < 1024; i++) begin
      pl_en = 1'b1;
      pl_addr = 10'(i);
      pl_data = 32'h5A5A_0000 ^ 32'(i);
      if (i == 'h10) pl_data = 32'h11;
      if (i == 'h20) pl_data = 32'h22;
      sample();
      advance();
    end
    pl_en = 1'b0;
    rst = 1'b1;

    // m0 write then read back.
    set_m0(1, 1, 10'h005, 32'hDEADBEEF);
    sample(); chk("t1_wr_gnt", 32'(m0_if.gnt), 1); advance();
    m0_if.req = 1'b0;
    sample();
    chk("t1_mem_write", 32'(mem_write), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h005);
    chk("t1_wr_ack", 32'(m0_if.ack), 1);
    advance();
    set_m0(1, 0, 10'h005, 32'h0);
    sample(); chk("t1_rd_gnt", 32'(m0_if.gnt), 1); advance();
    m0_if.req = 1'b0;
    sample(); chk("t1_mem_read", 32'(mem_read), 1); advance();
    sample();
    chk("t1_rd_ack", 32'(m0_if.ack), 1);
    chk("t1_rd_data", m0_if.rdata, 32'hDEADBEEF);
    advance();

    // Both read continuously: grants alternate, first to m0.
    reset_cycle();
    set_m0(1, 0, 10'h010, 32'h0);
    set_m1(1, 0, 10'h020, 32'h0);
    for (int k = 0; k < 12; k++) begin
      sample();
      if (k % 3 == 0) begin
        chk("t2_m0_gnt", 32'(m0_if.gnt), 32'((k / 3) % 2 == 0));
        chk("t2_m1_gnt", 32'(m1_if.gnt), 32'((k / 3) % 2 == 1));
      end else if (k % 3 == 2) begin
        if ((k / 3) % 2 == 0) begin
          chk("t2_m0_ack", 32'(m0_if.ack), 1);
          chk("t2_m0_rdata", m0_if.rdata, 32'h11);
          chk("t2_m1_rdata_idle", m1_if.rdata, 32'h0);
        end else begin
          chk("t2_m1_ack", 32'(m1_if.ack), 1);
          chk("t2_m1_rdata", m1_if.rdata, 32'h22);
          chk("t2_m0_rdata_idle", m0_if.rdata, 32'h0);
        end
      end
      advance();
    end
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;

    // Tie on 0x3FF after reset: m0 reads old value, then m1 writes.
    reset_cycle();
    set_m0(1, 0, 10'h3FF, 32'h0);
    set_m1(1, 1, 10'h3FF, 32'hCAFEF00D);
    for (int k = 0; k < 8; k++) begin
      sample();
      case (k)
        0: begin
          chk("t3_m0_gnt", 32'(m0_if.gnt), 1);
          chk("t3_m1_gnt_lose", 32'(m1_if.gnt), 0);
        end
        1: chk("t3_m1_gnt_busy", 32'(m1_if.gnt), 0);
        2: begin
          chk("t3_old_ack", 32'(m0_if.ack), 1);
          chk("t3_old_data", m0_if.rdata, 32'h5A5A03FF);
        end
        3: chk("t3_m1_gnt", 32'(m1_if.gnt), 1);
        4: begin
          chk("t3_mem_write", 32'(mem_write), 1);
          chk("t3_mem_addr", 32'(mem_addr), 32'h3FF);
          chk("t3_m1_ack", 32'(m1_if.ack), 1);
        end
        5: chk("t3_m0_gnt2", 32'(m0_if.gnt), 1);
        7: chk("t3_new_data", m0_if.rdata, 32'hCAFEF00D);
        default: ;
      endcase
      advance();
      if (k == 0) m0_if.req = 1'b0;
      if (k == 3) begin
        m1_if.req = 1'b0;
        set_m0(1, 0, 10'h3FF, 32'h0);
      end
      if (k == 5) m0_if.req = 1'b0;
    end

    // Reset during RDATA of an m1 read.
    reset_cycle();
    set_m1(1, 0, 10'h020, 32'h0);
    sample(); chk("t4_m1_gnt", 32'(m1_if.gnt), 1); advance();
    m1_if.req = 1'b0;
    sample(); chk("t4_mem_read", 32'(mem_read), 1); advance();
    rst = 1'b0;
    sample();
    chk("t4_no_ack", 32'(m1_if.ack), 0);
    chk("t4_no_rdata", m1_if.rdata, 32'h0);
    advance();
    rst = 1'b1;
    sample();
    chk("t4_after_ack", 32'(m1_if.ack), 0);
    chk("t4_after_read", 32'(mem_read), 0);
    advance();
    set_m0(1, 0, 10'h010, 32'h0);
    set_m1(1, 0, 10'h020, 32'h0);
    sample();
    chk("t4_tie_m0", 32'(m0_if.gnt), 1);
    chk("t4_tie_m1", 32'(m1_if.gnt), 0);
    advance();
    m0_if.req = 1'b0;

    // Random traffic; requests held until granted, occasional withdraw/reset.
    for (int i = 0; i < 10000; i++) begin
      sample();
      g0 = m0_if.gnt;
      g1 = m1_if.gnt;
      advance();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      if (!m0_if.req || g0)
        set_m0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
      else if ($urandom_range(0, 19) == 0)
        m0_if.req = 1'b0;
      if (!m1_if.req || g1)
        set_m1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
      else if ($urandom_range(0, 19) == 0)
        m1_if.req = 1'b0;
    end
    rst = 1'b1;
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares one single-port synchronous `memory` instance (1-cycle registered read, write on clock edge) between two requesters, e.g. instruction fetch (m0) and load/store (m1). It accepts one operation at a time with a req/gnt handshake, drives the memory's `read`/`write`/`address`/`data_input` pins, and returns an `ack` pulse to the owning requester, with read data on reads. It sits directly between the requesters and the memory.

## Interface
- `A_SIZE`, 10, address width; must match the memory.
- `D_SIZE`, 32, data width; must match the memory.

- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low: sampled on the rising edge of `clk`; `rst`=0 resets the block.
- `m0_req`, `m1_req`  in  1  operation requested; held with `we`/`addr`/`wdata` stable until `gnt`.
- `m0_we`, `m1_we`  in  1  1=write, 0=read.
- `m0_addr`, `m1_addr`  in  A_SIZE  word address.
- `m0_wdata`, `m1_wdata`  in  D_SIZE  write data.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational).
- `m0_ack`, `m1_ack`  out  1  one-cycle pulse when the operation completes.
- `m0_rdata`, `m1_rdata`  out  D_SIZE  read data; valid only with `ack` on a read; 0 otherwise.
- `mem_addr`  out  A_SIZE  to memory `address`.
- `mem_wdata`  out  D_SIZE  to memory `data_input`.
- `mem_read`, `mem_write`  out  1  to memory `read`/`write`; never both 1.
- `mem_rdata`  in  D_SIZE  from memory `data_output`.

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE: if any `req` is high, pick a winner, assert its `gnt`, and latch owner/we/addr/wdata into op registers. Next state is ISSUE. If no `req` is high, stay in IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the requester not equal to `last` wins.
  - `last` updates to the winner on every grant.
  - `last` resets to 1, so m0 wins the first tie.
- ISSUE: drive `mem_addr`/`mem_wdata` from the op registers.
  - Write: `mem_write`=1, owner `ack`=1, then IDLE. The memory commits at the end of this cycle.
  - Read: `mem_read`=1, then RDATA.
- RDATA: owner `ack`=1, owner `rdata`=`mem_rdata`, then IDLE. `mem_read`/`mem_write`=0.
- Outputs outside the active op: `gnt`, `ack`, and `rdata` of the non-owner are 0.
- A requester may keep `req` high after `gnt` to queue the next op. It must update `we`/`addr`/`wdata` in the cycle after `gnt`.
- `req` dropped before `gnt`: the request is withdrawn and no op is started.
- Reset (`rst`=0 at an edge):
  - state IDLE, `last`=1, op registers cleared.
  - All outputs are 0 during and after reset, including `gnt` (gated by `rst`).
  - An op in flight mid-reset is abandoned with no `ack`. A write that already reached ISSUE's edge stays committed.
  - Memory contents are not reset.

## Timing
- Write: `gnt` at cycle T (IDLE), `mem_write` and `ack` at T+1. Busy for 2 cycles.
- Read: `gnt` at T, `mem_read` at T+1, `ack`+`rdata` at T+2. Busy for 3 cycles.
- Next grant is possible in the cycle following the last busy cycle. Maximum throughput is 1 write per 2 cycles or 1 read per 3 cycles.
- `gnt` depends combinationally on `req`, state, `last`, and `rst`. All other outputs are decoded from registered state and the op registers (Moore). `rdata` passes combinationally from `mem_rdata`.
- No combinational path from `mem_rdata` to `gnt`.

## Structure
- Shared package/header `mem_arb_pkg`:
  - state encodings IDLE=2'b00, ISSUE=2'b01, RDATA=2'b10
  - owner constants OWN_M0=1'b0, OWN_M1=1'b1
- Sub-module `rr_arb2`: two-way round-robin picker. Inputs `req[1:0]` and `last`; outputs a one-hot `grant[1:0]` and `any`. Purely combinational. The `last` register lives in `mem_arbiter`.
- The memory is not instantiated inside this block; the top level connects it.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to 0x005 → `m0_gnt` at T, `mem_write`=1 with `mem_addr`=0x005 and `m0_ack` at T+1; then m0 reads 0x005 → `m0_ack` and `m0_rdata`=0xDEADBEEF two cycles after its `gnt`.
- m0 and m1 both read continuously (m0 at 0x010, m1 at 0x020, preloaded 0x11/0x22) → grants alternate m0, m1, m0, m1 with first grant to m0. Each `ack` returns the correct data to the correct port; the other port's `rdata` stays 0.
- m1 write to 0x3FF (wrap edge address) in the same cycle m0 requests a read of 0x3FF → m0 wins the tie after reset. m0 gets the old value; then m1 writes, and a subsequent m0 read returns the new value.
- Assert `rst`=0 during RDATA of an m1 read → no `m1_ack`. All outputs are 0 at the next edge; after release, the first tie goes to m0.
- Random `req`/`we` traffic for 10k cycles against a reference model → `mem_read` & `mem_write` never both 1. At most one `gnt` per cycle, only in IDLE. Every `gnt` is followed by exactly one `ack` unless reset intervenes.
